// File: rtl/wdt_rstreq.sv
// Watchdog / reset-request source: a fixed PULSE_LEN reset request on timeout or software request.
// Latency: request rises one edge after the trigger; every output is registered; no backpressure.
module wdt_rstreq #(
    parameter int CNT_W       = 24,
    parameter int TIMEOUT     = 1000000,
    parameter int WARN_CYCLES = 1000,
    parameter int PULSE_LEN   = 16
) (
    input  logic       CLK_I,
    input  logic       RESET_N_I,
    input  logic       EN_I,
    input  logic       KICK_I,
    input  logic       SWRST_I,
    input  logic       CLR_CAUSE_I,
    output logic       RSTREQ_O,
    output logic       WARN_O,
    output logic       ARMED_O,
    output logic [1:0] CAUSE_O
);

    localparam logic [CNT_W-1:0] RELOAD     = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] WARN_TH    = CNT_W'(WARN_CYCLES);
    localparam logic [7:0]       PULSE_LAST = 8'(PULSE_LEN - 1);
    localparam logic [1:0]       CAUSE_NONE = 2'b00;
    localparam logic [1:0]       CAUSE_WDT  = 2'b01;
    localparam logic [1:0]       CAUSE_SW   = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_COUNT, S_FIRE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       pulse_cnt;
    logic [CNT_W-1:0] cnt_dec;

    assign cnt_dec = cnt - CNT_W'(1);

    always_ff @(posedge CLK_I or negedge RESET_N_I) begin
        if (!RESET_N_I) begin
            state     <= S_IDLE;
            cnt       <= RELOAD;
            pulse_cnt <= '0;
            RSTREQ_O  <= 1'b0;
            WARN_O    <= 1'b0;
            ARMED_O   <= 1'b0;
            CAUSE_O   <= CAUSE_NONE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (SWRST_I) begin
                        state     <= S_FIRE;
                        pulse_cnt <= PULSE_LAST;
                        RSTREQ_O  <= 1'b1;
                        CAUSE_O   <= CAUSE_SW;
                    end else begin
                        if (CLR_CAUSE_I)
                            CAUSE_O <= CAUSE_NONE;
                        if (EN_I) begin
                            state   <= S_COUNT;
                            cnt     <= RELOAD;
                            ARMED_O <= 1'b1;
                        end
                    end
                end
                S_COUNT: begin
                    // Software request outranks a kick, and a kick outranks expiry.
                    if (SWRST_I) begin
                        state     <= S_FIRE;
                        pulse_cnt <= PULSE_LAST;
                        RSTREQ_O  <= 1'b1;
                        WARN_O    <= 1'b0;
                        CAUSE_O   <= CAUSE_SW;
                    end else if (KICK_I) begin
                        cnt    <= RELOAD;
                        WARN_O <= 1'b0;
                        if (CLR_CAUSE_I)
                            CAUSE_O <= CAUSE_NONE;
                    end else if (cnt == '0) begin
                        state     <= S_FIRE;
                        pulse_cnt <= PULSE_LAST;
                        RSTREQ_O  <= 1'b1;
                        WARN_O    <= 1'b0;
                        CAUSE_O   <= CAUSE_WDT;
                    end else begin
                        cnt    <= cnt_dec;
                        WARN_O <= (cnt_dec < WARN_TH);
                        if (CLR_CAUSE_I)
                            CAUSE_O <= CAUSE_NONE;
                    end
                end
                S_FIRE: begin
                    if (pulse_cnt == 8'd0) begin
                        state    <= S_IDLE;
                        RSTREQ_O <= 1'b0;
                        ARMED_O  <= 1'b0;
                        cnt      <= RELOAD;
                    end else begin
                        pulse_cnt <= pulse_cnt - 8'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
